regfile_wb_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's single write port among NREQ write-back requesters (e.g. ALU, load unit, multiplier, CSR path). It accepts one write per cycle via a valid/ready handshake and registers the winner's address and data. It produces the 32-bit one-hot register write-enable vector that drives the register file's write-port decoder. It also discards writes to r0 and counts them.

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_dec.sv | 17 +
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int NREGS      = 32;
    localparam int AW         = 5;
    localparam int DW         = 32;
    localparam int DROP_CNT_W = 8;
    localparam int GID_W      = 3;

    localparam logic [AW-1:0] ZERO_REG = '0;

    // Saturating increment: the drop counter sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_dec.sv
// 5-to-32 one-hot decoder with enable; drives the register file write-enable lines.
module onehot_dec5
    import regfile_wb_arbiter_pkg::*;
(
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    output logic [NREGS-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// write-back requesters; writes to r0 are accepted but suppressed and counted.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = regfile_wb_arbiter_pkg::DW,
    parameter int AW   = regfile_wb_arbiter_pkg::AW
) (
    input  logic                                          clk,
    input  logic                                          clrn,
    input  logic                                          stall,
    input  logic [NREQ-1:0]                               req_valid,
    input  logic [NREQ*AW-1:0]                            req_addr,
    input  logic [NREQ*DW-1:0]                            req_data,
    output logic [NREQ-1:0]                               req_ready,
    output logic [regfile_wb_arbiter_pkg::NREGS-1:0]      we,
    output logic [AW-1:0]                                 wa,
    output logic [DW-1:0]                                 wd,
    output logic                                          wr_valid,
    output logic [regfile_wb_arbiter_pkg::GID_W-1:0]      grant_id,
    output logic [regfile_wb_arbiter_pkg::DROP_CNT_W-1:0] drop_cnt
);
    import regfile_wb_arbiter_pkg::GID_W;
    import regfile_wb_arbiter_pkg::DROP_CNT_W;
    import regfile_wb_arbiter_pkg::ZERO_REG;
    import regfile_wb_arbiter_pkg::sat_inc;

    logic [GID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GID_W-1:0]      win_idx;
    logic                  win_found;
    logic                  xfer;
    logic [AW-1:0]         win_addr;
    logic [DW-1:0]         win_data;
    logic [7:0]            valid_ext;
    logic                  wr_valid_q;
    logic [AW-1:0]         wa_q;
    logic [DW-1:0]         wd_q;
    logic [GID_W-1:0]      grant_id_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [GID_W-1:0] wrap_add(input logic [GID_W-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return GID_W'(s);
    endfunction

    // Zero-padded to 8 so slots at or above NREQ can never win the search.
    assign valid_ext = 8'(req_valid);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && valid_ext[wrap_add(rr_ptr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == GID_W'(k)) begin
                win_addr = req_addr[k*AW +: AW];
                win_data = req_data[k*DW +: DW];
            end
        end
    end

    assign xfer = win_found && !stall;

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (xfer && clrn && (win_idx == GID_W'(k))) begin
                req_ready[k] = 1'b1;
            end
        end
    end

    assign rr_ptr_d   = !xfer ? rr_ptr_q :
                        (win_idx == GID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    assign drop_cnt_d = (xfer && (win_addr == ZERO_REG)) ? sat_inc(drop_cnt_q) : drop_cnt_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rr_ptr_q   <= '0;
            wr_valid_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            grant_id_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= xfer;
            drop_cnt_q <= drop_cnt_d;
            if (xfer) begin
                wa_q       <= win_addr;
                wd_q       <= win_data;
                grant_id_q <= win_idx;
            end
        end
    end

    onehot_dec5 u_dec (
        .en_i   (wr_valid_q && (wa_q != ZERO_REG)),
        .addr_i (wa_q),
        .dec_o  (we)
    );

    assign wa       = wa_q;
    assign wd       = wd_q;
    assign wr_valid = wr_valid_q;
    assign grant_id = grant_id_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected writes, a
// negedge monitor pops and compares them against the registered write port.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [2:0]  g;
        logic [31:0] we;
        int          cyc;
    } exp_t;

    logic         clk;
    logic         clrn;
    logic         stall;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic         wr_valid;
    logic [2:0]   grant_id;
    logic [7:0]   drop_cnt;

    logic [4:0]   a_arr [4];
    logic [31:0]  d_arr [4];
    exp_t         exp_q [$];
    logic [3:0]   exp_ready;
    logic [7:0]   exp_drop;
    logic         chk_drop;
    logic         done;
    int           cyc;
    int           vec;
    int           miss;

    regfile_wb_arbiter #(.NREQ(4), .DW(32), .AW(5)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .wr_valid  (wr_valid),
        .grant_id  (grant_id),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int k = 0; k < 4; k++) begin
            req_addr[k*5 +: 5]   = a_arr[k];
            req_data[k*32 +: 32] = d_arr[k];
        end
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] we_of(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (32'd1 << a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vec = vec + 1;
        if (act !== expv) begin
            miss = miss + 1;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: every comparison in the bench happens here.
    initial begin
        vec  = 0;
        miss = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (chk_drop) check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        if ((exp_q.size() > 0) && (exp_q[0].cyc == cyc - 1)) begin
            e = exp_q.pop_front();
            check("wr_valid", 32'(wr_valid), 32'd1);
            check("wa", 32'(wa), 32'(e.a));
            check("wd", wd, e.d);
            check("grant_id", 32'(grant_id), 32'(e.g));
            check("we", we, e.we);
        end else begin
            check("wr_valid_idle", 32'(wr_valid), 32'd0);
            check("we_idle", we, 32'd0);
        end
        if (done) begin
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
            $finish;
        end
    end

    // Requester rule: a pending request must hold valid, address and data.
    logic [3:0]  pend;
    logic [4:0]  sa [4];
    logic [31:0] sd [4];
    always @(posedge clk) begin
        if (!clrn) begin
            pend <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pend[k]) begin
                    assert (req_valid[k] && (a_arr[k] == sa[k]) && (d_arr[k] == sd[k]))
                        else $error("requester %0d stability violation", k);
                end
                pend[k] <= req_valid[k] && !req_ready[k];
                sa[k]   <= a_arr[k];
                sd[k]   <= d_arr[k];
            end
        end
    end

    task automatic drive(input logic [3:0] v, input logic [3:0] rdy);
        exp_t e;
        req_valid = v;
        exp_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                e.a   = a_arr[i];
                e.d   = d_arr[i];
                e.g   = 3'(i);
                e.we  = we_of(a_arr[i]);
                e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn      = 1'b0;
        stall     = 1'b0;
        req_valid = 4'b1111;
        exp_ready = 4'b0000;
        exp_drop  = 8'd0;
        chk_drop  = 1'b1;
        done      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_arr[k] = 5'(10 + k);
            d_arr[k] = 32'hA5A5_0000 | 32'(k);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clrn      = 1'b1;
        req_valid = 4'b0000;

        repeat (10) drive(4'b0000, 4'b0000);
        chk_drop = 1'b0;

        // Round-robin from pointer 0, then drain the three still-pending requesters.
        for (int c = 0; c < 8; c++) drive(4'b1111, 4'(4'b0001 << (c % 4)));
        drive(4'b0111, 4'b0001);
        drive(4'b0110, 4'b0010);
        drive(4'b0100, 4'b0100);

        // Single write; pointer is 3 so requester 1 still wins.
        a_arr[1] = 5'd7;
        d_arr[1] = 32'hDEAD_BEEF;
        drive(4'b0010, 4'b0010);
        drive(4'b0000, 4'b0000);

        // r0 writes: 256 in total, counter must saturate at 255.
        a_arr[2] = 5'd0;
        d_arr[2] = 32'h1234_5678;
        repeat (3) drive(4'b0100, 4'b0100);
        exp_drop = 8'd3;
        chk_drop = 1'b1;
        drive(4'b0100, 4'b0100);
        chk_drop = 1'b0;
        repeat (250) drive(4'b0100, 4'b0100);
        exp_drop = 8'd254;
        chk_drop = 1'b1;
        drive(4'b0100, 4'b0100);
        chk_drop = 1'b0;
        drive(4'b0100, 4'b0100);
        exp_drop = 8'd255;
        chk_drop = 1'b1;
        drive(4'b0000, 4'b0000);
        chk_drop = 1'b0;

        // Stall with pointer at 3: no grant, then 0 before 2.
        a_arr[0] = 5'd3;
        d_arr[0] = 32'h0000_0303;
        a_arr[2] = 5'd4;
        d_arr[2] = 32'h0000_0404;
        stall = 1'b1;
        repeat (3) drive(4'b0101, 4'b0000);
        stall = 1'b0;
        drive(4'b0101, 4'b0001);
        drive(4'b0100, 4'b0100);
        drive(4'b0000, 4'b0000);

        // Reset right after a handshake to r9: the write must be discarded.
        a_arr[1]  = 5'd9;
        d_arr[1]  = 32'h0909_0909;
        req_valid = 4'b0010;
        exp_ready = 4'b0010;
        @(posedge clk);
        #1;
        clrn      = 1'b0;
        req_valid = 4'b0000;
        exp_ready = 4'b0000;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        clrn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_arr[k] = 5'(20 + k);
            d_arr[k] = 32'hC0DE_0000 | 32'(k);
        end
        // Pointer was 2 before reset; after reset requester 0 must win.
        drive(4'b1111, 4'b0001);
        drive(4'b1110, 4'b0010);
        drive(4'b1100, 4'b0100);
        drive(4'b1000, 4'b1000);
        drive(4'b0000, 4'b0000);
        drive(4'b0000, 4'b0000);
        done = 1'b1;
    end

endmodule
